rob_queue: RTL and testbench
============================

// Module: rob_queue
// PURPOSE
//  One reorder buffer per order id (instantiated 7x, ids 1..7); the responder side of the writeback ROB interface.
//  Allocates entries in order to the execute stage and accepts out-of-order completions from writeback (wr1_*).
//  Presents the in-order head entry on rd_data_o; pops it on rd1_en_i.
//  Retires "already output" skip markers at the head without presenting them.
// PARAMETERS
//  info_length   20  lookup sideband width
//  register_num  32  request register file depth; register_width = clogb(register_num)
//  rob_num       16  entries (power of 2); rob_width = clogb(rob_num)
//  rob_data_length (local) = 1+register_width+info_length+1+1
// PORTS
//  clk            in   1                clock, single domain
//  rst            in   1                asynchronous, active-low reset
//  alloc_req_i    in   1                execute requests an entry
//  alloc_gnt_o    out  1                entry granted this cycle
//  alloc_entry_o  out  rob_width        granted entry index (= tail)
//  rob_full_o     out  1                rob_num entries allocated
//  rob_empty_o    out  1                no entries allocated
//  rob_count_o    out  rob_width+1      allocated entries
//  wr1_data_i     in   rob_data_length  completion record from writeback
//  wr1_addr_i     in   rob_width        entry being completed
//  wr1_en_i       in   1                completion write strobe
//  rd1_en_i       in   1                writeback pops the head this cycle
//  rd_data_o      out  rob_data_length  head record when ready, else 0
//  rob_err_o      out  1                sticky protocol error flag
// BEHAVIOUR
//  Record layout: [MSB] ready | [req_addr] register_width | [info] info_length | [1] so | [0] skip.
//  State: mem[rob_num], alloc_v[rob_num], done_v[rob_num]; head/tail are rob_width+1 bits with a wrap bit.
//  count = tail-head. full = (count==rob_num). empty = (count==0).
//  Reset (rst=0, any time, including mid-operation): head=tail=0, alloc_v=done_v=0, err=0.
//   Reset output values: gnt=0, entry=0, full=0, empty=1, count=0, rd_data_o=0, err=0. mem contents are don't-care.
//  Alloc (comb): alloc_gnt_o = alloc_req_i & ~rob_full_o, using the registered full only.
//   A same-cycle retire does not unblock a full ROB.
//   On gnt at the clock edge: alloc_v[tail]=1, done_v[tail]=0, mem[tail]=0, tail++ (wraps through the wrap bit).
//  Write: at the edge with wr1_en_i=1, accepted only if alloc_v[addr]=1 and done_v[addr]=0.
//   Accepted: mem[addr]=wr1_data_i, done_v[addr]=1.
//   Otherwise the write is dropped and err is set.
//  Head (comb from registers): hv = alloc_v[head] & done_v[head].
//   ready = hv & mem[head][MSB]; rd_data_o = ready ? mem[head] : 0.
//   Latency: a completion written at edge N is visible on rd_data_o in cycle N+1 if it is at the head.
//  Skip: hv & ~mem[head][MSB] & mem[head][0] (writeback writes value 1) retires automatically at the next edge.
//   Retire: alloc_v[head]=0, head++. rd_data_o stays 0 for that entry.
//  Pop: rd1_en_i & ready retires the head at the edge.
//   rd1_en_i while not ready: ignored, err set.
//  Retire limit: at most one retire per cycle (pop or skip).
//   Back-to-back skip markers retire one per cycle.
//  Simultaneous events:
//   alloc + retire in one cycle: both happen; count unchanged.
//   write to entry X + pop of head: independent; a write to the head being popped is rejected because done_v is already set.
//   alloc of entry E + write to E in the same cycle: write rejected (alloc_v is still 0), err set.
//  Data done_v with MSB=0 and bit0=0 at the head: treated as a stall. Head holds; no error.
// STRUCTURE
//  Shared package/header: clogb; record field offsets (ready bit, req_addr_start/end, info_start/end, so bit, skip bit).
//   Writeback uses the same offsets.
//  One sub-module: rob_wrap_ptr (rob_width+1 bit incrementing pointer with an enable). Used for head and tail.
// TESTING
//  1. Reset -> empty=1, full=0, count=0, rd_data_o=0, gnt=0.
//     alloc_req 3 cycles -> entries 0,1,2; count=3.
//  2. Alloc 0..2; write entry 2 then 0 (ready=1, so=1, info=20'hABCDE, req_addr=5).
//     -> rd_data_o shows entry 0 the cycle after its write. Pop -> head=1, rd_data_o=0 until entry 1 is written.
//  3. Alloc 0..1; write 'b1 to entry 0 and a ready record to entry 1.
//     -> entry 0 retires with no rd_data_o; entry 1 is presented one cycle later.
//  4. Allocate 16 entries -> full=1, gnt=0 while req=1.
//     Complete and pop the head with alloc_req=1 -> gnt only in the cycle after full falls.
//     Continue 40 cycles to wrap head/tail and check index order 0..15,0..
//  5. Protocol errors: write to an unallocated entry, a double write to entry 3, rd1_en_i with no ready head
//     -> err=1 (sticky), ROB state unchanged.
//  6. Drop rst mid-traffic with 10 entries allocated -> all outputs return to reset values asynchronously.
//     After release the first gnt gives entry 0.

Source files
------------

// File: rtl/rob_queue_pkg.sv
// Shared definitions for the writeback reorder buffer: sizing helper and record field offsets.
// The writeback stage builds its completion records from the same offsets.
package rob_queue_pkg;

  localparam int INFO_LENGTH  = 20;
  localparam int REGISTER_NUM = 32;
  localparam int ROB_NUM      = 16;

  localparam int SKIP_BIT   = 0;
  localparam int SO_BIT     = 1;
  localparam int INFO_START = 2;

  function automatic int clogb(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic int info_end(input int info_length);
    return INFO_START + info_length - 1;
  endfunction

  function automatic int req_addr_start(input int info_length);
    return INFO_START + info_length;
  endfunction

  function automatic int req_addr_end(input int info_length, input int register_width);
    return INFO_START + info_length + register_width - 1;
  endfunction

  function automatic int ready_bit(input int info_length, input int register_width);
    return INFO_START + info_length + register_width;
  endfunction

endpackage

// File: rtl/rob_wrap_ptr.sv
// Incrementing pointer with an extra wrap bit; used for both head and tail of the ROB.
module rob_wrap_ptr #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [width-1:0] ptr_o
);

  logic [width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + width'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_queue.sv
// Per-order-id reorder buffer: in-order allocation, out-of-order completion, in-order pop,
// with automatic retirement of skip markers at the head.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter  int info_length     = INFO_LENGTH,
  parameter  int register_num    = REGISTER_NUM,
  parameter  int rob_num         = ROB_NUM,
  localparam int register_width  = clogb(register_num),
  localparam int rob_width       = clogb(rob_num),
  localparam int rob_data_length = 1 + register_width + info_length + 1 + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [rob_width-1:0]       alloc_entry_o,
  output logic                       rob_full_o,
  output logic                       rob_empty_o,
  output logic [rob_width:0]         rob_count_o,
  input  logic [rob_data_length-1:0] wr1_data_i,
  input  logic [rob_width-1:0]       wr1_addr_i,
  input  logic                       wr1_en_i,
  input  logic                       rd1_en_i,
  output logic [rob_data_length-1:0] rd_data_o,
  output logic                       rob_err_o
);

  localparam int RDY = ready_bit(info_length, register_width);

  logic [rob_width:0]         head_ptr, tail_ptr, count;
  logic [rob_width-1:0]       head_idx, tail_idx;
  logic [rob_num-1:0]         alloc_v_q, alloc_v_d, done_v_q, done_v_d;
  logic                       err_q, err_d;
  logic [rob_data_length-1:0] mem [rob_num];
  logic [rob_data_length-1:0] head_rec;
  logic                       full, gnt, wr_ok, hv, ready, skip, retire;

  rob_wrap_ptr #(.width(rob_width + 1)) u_head_ptr (
    .clk(clk), .rst(rst), .en_i(retire), .ptr_o(head_ptr)
  );

  rob_wrap_ptr #(.width(rob_width + 1)) u_tail_ptr (
    .clk(clk), .rst(rst), .en_i(gnt), .ptr_o(tail_ptr)
  );

  assign head_idx = head_ptr[rob_width-1:0];
  assign tail_idx = tail_ptr[rob_width-1:0];
  assign count    = tail_ptr - head_ptr;
  assign full     = (count == (rob_width + 1)'(rob_num));

  // Grant uses only registered fullness, and is held low while reset is asserted.
  assign gnt   = alloc_req_i & ~full & rst;
  assign wr_ok = wr1_en_i & alloc_v_q[wr1_addr_i] & ~done_v_q[wr1_addr_i];

  assign head_rec = mem[head_idx];
  assign hv       = alloc_v_q[head_idx] & done_v_q[head_idx];
  assign ready    = hv & head_rec[RDY];
  assign skip     = hv & ~head_rec[RDY] & head_rec[SKIP_BIT];
  // Pop and skip are exclusive through the ready bit, so at most one retire per cycle.
  assign retire   = (rd1_en_i & ready) | skip;

  always_comb begin
    alloc_v_d = alloc_v_q;
    done_v_d  = done_v_q;
    err_d     = err_q | (wr1_en_i & ~wr_ok) | (rd1_en_i & ~ready);
    if (wr_ok) done_v_d[wr1_addr_i] = 1'b1;
    if (retire) alloc_v_d[head_idx] = 1'b0;
    if (gnt) begin
      alloc_v_d[tail_idx] = 1'b1;
      done_v_d[tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_v_q <= '0;
      done_v_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      alloc_v_q <= alloc_v_d;
      done_v_q  <= done_v_d;
      err_q     <= err_d;
    end
  end

  // A granted tail is never writable in the same cycle, so the two writes never collide.
  always_ff @(posedge clk) begin
    if (gnt)   mem[tail_idx]   <= '0;
    if (wr_ok) mem[wr1_addr_i] <= wr1_data_i;
  end

  assign alloc_gnt_o   = gnt;
  assign alloc_entry_o = tail_idx;
  assign rob_full_o    = full;
  assign rob_empty_o   = (count == '0);
  assign rob_count_o   = count;
  assign rd_data_o     = ready ? head_rec : '0;
  assign rob_err_o     = err_q;

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue with a queue-level reference model checked every cycle.
module tb_rob_queue;

  localparam int DL = 28;
  localparam logic [DL-1:0] REC_A = {1'b1, 5'd5, 20'hABCDE, 1'b1, 1'b0};
  localparam logic [DL-1:0] REC_B = {1'b1, 5'd7, 20'h12345, 1'b0, 1'b0};
  localparam logic [DL-1:0] REC_SKIP = 28'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alloc_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [DL-1:0] wr_data = '0;
  logic gnt_o, full_o, empty_o, err_o;
  logic [3:0] entry_o;
  logic [4:0] count_o;
  logic [DL-1:0] rd_o;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: monotonically increasing head/tail counters; live entries are [head, tail).
  int m_head = 0, m_tail = 0;
  bit m_done[16];
  logic [DL-1:0] m_data[16];
  bit m_err = 1'b0;

  rob_queue dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req), .alloc_gnt_o(gnt_o), .alloc_entry_o(entry_o),
    .rob_full_o(full_o), .rob_empty_o(empty_o), .rob_count_o(count_o),
    .wr1_data_i(wr_data), .wr1_addr_i(wr_addr), .wr1_en_i(wr_en),
    .rd1_en_i(rd_en), .rd_data_o(rd_o), .rob_err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    return m_tail - m_head;
  endfunction

  function automatic bit m_full();
    return m_count() == 16;
  endfunction

  function automatic bit m_gnt();
    return rst && alloc_req && !m_full();
  endfunction

  function automatic bit m_live(input int a);
    return ((a - (m_head % 16) + 16) % 16) < m_count();
  endfunction

  function automatic bit m_ready();
    int h;
    h = m_head % 16;
    return (m_count() > 0) && m_done[h] && (m_data[h][DL-1] == 1'b1);
  endfunction

  function automatic bit m_skip();
    int h;
    h = m_head % 16;
    return (m_count() > 0) && m_done[h] && (m_data[h][DL-1] == 1'b0) && (m_data[h][0] == 1'b1);
  endfunction

  function automatic logic [DL-1:0] m_rd();
    if (m_ready()) return m_data[m_head % 16];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_head = 0;
      m_tail = 0;
      m_err  = 1'b0;
      for (int i = 0; i < 16; i++) m_done[i] = 1'b0;
    end else begin
      bit g, acc, ret;
      g   = m_gnt();
      acc = wr_en && m_live(int'(wr_addr)) && !m_done[wr_addr];
      ret = (rd_en && m_ready()) || m_skip();
      if ((wr_en && !acc) || (rd_en && !m_ready())) m_err = 1'b1;
      if (acc) begin
        m_done[wr_addr] = 1'b1;
        m_data[wr_addr] = wr_data;
      end
      if (ret) m_head++;
      if (g) begin
        m_done[m_tail % 16] = 1'b0;
        m_data[m_tail % 16] = '0;
        m_tail++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_gnt", 32'(gnt_o), 32'(m_gnt()));
      chk("cyc_entry", 32'(entry_o), 32'(m_tail % 16));
      chk("cyc_full", 32'(full_o), 32'(m_full()));
      chk("cyc_empty", 32'(empty_o), 32'(m_count() == 0));
      chk("cyc_count", 32'(count_o), 32'(m_count()));
      chk("cyc_rd_data", 32'(rd_o), 32'(m_rd()));
      chk("cyc_err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [DL-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    // Reset values and first allocations
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_rd_data", 32'(rd_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_err", 32'(err_o), 0);
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1;
      #1;
      chk("alloc_entry", 32'(entry_o), 32'(i));
      chk("alloc_gnt", 32'(gnt_o), 1);
      tick();
    end
    alloc_req = 1'b0;
    #1 chk("count3", 32'(count_o), 3);

    // Out-of-order completion and in-order pop
    wr(4'd2, REC_A);
    chk("head_not_ready", 32'(rd_o), 0);
    wr(4'd0, REC_A);
    chk("head_visible", 32'(rd_o), 32'(REC_A));
    pop();
    chk("after_pop_rd", 32'(rd_o), 0);
    chk("after_pop_count", 32'(count_o), 2);
    wr(4'd1, REC_B);
    chk("entry1_visible", 32'(rd_o), 32'(REC_B));
    pop();
    chk("entry2_visible", 32'(rd_o), 32'(REC_A));
    pop();
    chk("drained_empty", 32'(empty_o), 1);

    // Skip marker at the head retires without presentation (entries 3,4)
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req = 1'b0;
    wr(4'd4, REC_B);
    wr(4'd3, REC_SKIP);
    chk("skip_hidden", 32'(rd_o), 0);
    chk("skip_count", 32'(count_o), 2);
    tick();
    chk("after_skip_rd", 32'(rd_o), 32'(REC_B));
    chk("after_skip_count", 32'(count_o), 1);
    pop();

    // Full ROB, blocked grant, then wrap-around traffic
    alloc_req = 1'b1;
    repeat (16) tick();
    chk("full_set", 32'(full_o), 1);
    chk("full_no_gnt", 32'(gnt_o), 0);
    chk("full_count", 32'(count_o), 16);
    wr(4'd5, REC_A);
    rd_en = 1'b1;
    #1 chk("retire_no_unblock", 32'(gnt_o), 0);
    tick();
    rd_en = 1'b0;
    #1;
    chk("full_fell", 32'(full_o), 0);
    chk("gnt_after_full", 32'(gnt_o), 1);
    chk("gnt_entry", 32'(entry_o), 5);
    for (int i = 0; i < 40; i++) begin
      wr(4'(m_head % 16), {1'b1, 5'(i), 20'(i * 7), 2'b10});
      pop();
    end
    alloc_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_count() > 0) begin
        wr(4'(m_head % 16), {1'b1, 5'(i), 20'(i + 3), 2'b00});
        pop();
      end
    end
    chk("wrap_drained", 32'(empty_o), 1);

    // Protocol errors leave state untouched
    alloc_req = 1'b1;
    repeat (5) tick();
    alloc_req = 1'b0;
    chk("pre_err", 32'(err_o), 0);
    wr(4'((m_head + 8) % 16), REC_A);
    chk("err_unalloc", 32'(err_o), 1);
    chk("err_count", 32'(count_o), 5);
    wr(4'((m_head + 3) % 16), REC_A);
    wr(4'((m_head + 3) % 16), REC_B);
    chk("err_sticky", 32'(err_o), 1);
    pop();
    chk("bad_pop_count", 32'(count_o), 5);
    chk("bad_pop_rd", 32'(rd_o), 0);
    alloc_req = 1'b1;
    wr(4'(m_tail % 16), REC_A);
    alloc_req = 1'b0;
    chk("alloc_write_count", 32'(count_o), 6);

    // Asynchronous reset mid-traffic with 10 entries allocated
    alloc_req = 1'b1;
    repeat (4) tick();
    chk("ten_alloc", 32'(count_o), 10);
    wr_en = 1'b1;
    wr_addr = 4'(m_head % 16);
    wr_data = REC_A;
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty_o), 1);
    chk("arst_full", 32'(full_o), 0);
    chk("arst_count", 32'(count_o), 0);
    chk("arst_rd", 32'(rd_o), 0);
    chk("arst_gnt", 32'(gnt_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_entry", 32'(entry_o), 0);
    alloc_req = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 alloc_req = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(gnt_o), 1);
    chk("post_rst_entry", 32'(entry_o), 0);
    tick();
    alloc_req = 1'b0;
    chk("post_rst_count", 32'(count_o), 1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
